// File: rtl/memtrace_lane_serializer.sv
// Serializes a vector of memory-trace lanes onto a single request port, lowest lane first,
// while tracking outstanding requests against a fixed credit limit.
module memtrace_lane_serializer #(
    parameter int unsigned NUM_LANES       = 4,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MASK_WIDTH      = 8,
    parameter int unsigned MAX_OUTSTANDING = 16,
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    output logic                             in_ready,
    input  logic [NUM_LANES-1:0]             in_valid,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]  in_address,
    input  logic [NUM_LANES-1:0]             in_is_store,
    input  logic [MASK_WIDTH*NUM_LANES-1:0]  in_store_mask,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]  in_data,
    input  logic                             in_finished,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [LANE_W-1:0]                mem_req_lane,
    output logic [DATA_WIDTH-1:0]            mem_req_address,
    output logic                             mem_req_is_store,
    output logic [MASK_WIDTH-1:0]            mem_req_mask,
    output logic [DATA_WIDTH-1:0]            mem_req_data,
    input  logic                             mem_resp_valid,
    output logic [OUT_W-1:0]                 outstanding,
    output logic [31:0]                      req_count,
    output logic                             finished,
    output logic                             resp_error
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic [NUM_LANES-1:0]   pending_q, pending_d;
    logic                   fin_seen_q, fin_seen_d;
    logic [OUT_W-1:0]       outstanding_q, outstanding_d;
    logic [31:0]            req_count_q;
    logic                   finished_q;
    logic                   resp_error_q, resp_error_set;

    logic [DATA_WIDTH-1:0]  addr_q [NUM_LANES];
    logic [DATA_WIDTH-1:0]  data_q [NUM_LANES];
    logic [MASK_WIDTH-1:0]  mask_q [NUM_LANES];
    logic [NUM_LANES-1:0]   store_q;

    logic [LANE_W-1:0]      issue_lane;
    logic                   latch_vec;
    logic                   handshake;

    // Reset gates the handshake outputs combinationally so nothing leaks while held.
    assign in_ready      = reset && (state_q == StIdle);
    assign mem_req_valid = reset && (state_q == StIssue) &&
                           (outstanding_q != OUT_W'(MAX_OUTSTANDING));
    assign handshake     = mem_req_valid && mem_req_ready;
    assign latch_vec     = in_ready && (|in_valid);

    always_comb begin
        issue_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                issue_lane = LANE_W'(i);
            end
        end
    end

    assign mem_req_lane     = issue_lane;
    assign mem_req_address  = addr_q[issue_lane];
    assign mem_req_is_store = store_q[issue_lane];
    assign mem_req_mask     = mask_q[issue_lane];
    assign mem_req_data     = data_q[issue_lane];

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        fin_seen_d = fin_seen_q;
        unique case (state_q)
            StIdle: begin
                if (|in_valid) begin
                    pending_d  = in_valid;
                    fin_seen_d = in_finished;
                    state_d    = StIssue;
                end else if (in_finished) begin
                    state_d = StDrain;
                end
            end
            StIssue: begin
                if (handshake) begin
                    pending_d[issue_lane] = 1'b0;
                    if (pending_d == '0) begin
                        state_d = fin_seen_q ? StDrain : StIdle;
                    end
                end
            end
            StDrain: begin
                if (outstanding_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A response with nothing in flight is flagged and never underflows the counter.
    always_comb begin
        outstanding_d  = outstanding_q;
        resp_error_set = mem_resp_valid && (outstanding_q == '0);
        if (handshake && !mem_resp_valid) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (mem_resp_valid && !handshake && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            fin_seen_q    <= 1'b0;
            outstanding_q <= '0;
            req_count_q   <= '0;
            finished_q    <= 1'b0;
            resp_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            fin_seen_q    <= fin_seen_d;
            outstanding_q <= outstanding_d;
            if (handshake) begin
                req_count_q <= req_count_q + 32'd1;
            end
            finished_q    <= finished_q | (state_d == StDone);
            resp_error_q  <= resp_error_q | resp_error_set;
        end
    end

    always_ff @(posedge clock) begin
        if (latch_vec) begin
            for (int g = 0; g < NUM_LANES; g++) begin
                addr_q[g]  <= in_address[g*DATA_WIDTH +: DATA_WIDTH];
                data_q[g]  <= in_data[g*DATA_WIDTH +: DATA_WIDTH];
                mask_q[g]  <= in_store_mask[g*MASK_WIDTH +: MASK_WIDTH];
                store_q[g] <= in_is_store[g];
            end
        end
    end

    assign outstanding = outstanding_q;
    assign req_count   = req_count_q;
    assign finished    = finished_q;
    assign resp_error  = resp_error_q;

endmodule

// File: doc/memtrace_lane_serializer.md
MEMTRACE_LANE_SERIALIZER -- requirements
Module: memtrace_lane_serializer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of trace lanes per vector.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: address and data width per lane.
REQ-003 SHALL have parameter MASK_WIDTH, default 8: store byte-mask width per lane.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 16: maximum number of un-responded memory requests.
REQ-005 SHALL have port clock, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port in_ready, output, 1: the lane vector is consumed this cycle; drives the trace source's ready.
REQ-008 SHALL have port in_valid, input, NUM_LANES: per-lane request valid.
REQ-009 SHALL have port in_address, input, DATA_WIDTH*NUM_LANES: lane g occupies bits [DATA_WIDTH*(g+1)-1 : DATA_WIDTH*g].
REQ-010 SHALL have port in_is_store, input, NUM_LANES: per-lane store flag.
REQ-011 SHALL have port in_store_mask, input, MASK_WIDTH*NUM_LANES: per-lane store mask, packed the same way as in_address.
REQ-012 SHALL have port in_data, input, DATA_WIDTH*NUM_LANES: per-lane store data, packed the same way as in_address.
REQ-013 SHALL have port in_finished, input, 1: the trace source has no further requests.
REQ-014 SHALL have ports mem_req_valid (output, 1) and mem_req_ready (input, 1): single-port memory request handshake.
REQ-015 SHALL have ports mem_req_lane (output, clog2(NUM_LANES)), mem_req_address (output, DATA_WIDTH), mem_req_is_store (output, 1), mem_req_mask (output, MASK_WIDTH), mem_req_data (output, DATA_WIDTH): payload of the lane being issued.
REQ-016 SHALL have port mem_resp_valid, input, 1: one response; always accepted, no ready.
REQ-017 SHALL have port outstanding, output, clog2(MAX_OUTSTANDING+1): current count of un-responded requests.
REQ-018 SHALL have port req_count, output, 32: total requests issued since reset; wraps modulo 2^32.
REQ-019 SHALL have port finished, output, 1: sticky; trace fully drained.
REQ-020 SHALL have port resp_error, output, 1: sticky; a response arrived with outstanding == 0.

Function
REQ-021 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-022 IDLE: in_ready = 1; if in_valid != 0, SHALL latch all lane payloads, latch pending = in_valid, latch fin_seen = in_finished, and go to ISSUE.
REQ-023 IDLE with in_valid == 0 and in_finished = 1 SHALL go to DRAIN; with in_valid == 0 and in_finished = 0, SHALL stay in IDLE and latch nothing.
REQ-024 ISSUE: in_ready = 0; the issued lane SHALL be the lowest set bit of pending; mem_req_* SHALL carry that lane's latched payload.
REQ-025 ISSUE: mem_req_valid SHALL equal (outstanding != MAX_OUTSTANDING); a response arriving in the same cycle SHALL NOT raise valid.
REQ-026 On a handshake (mem_req_valid && mem_req_ready), the block SHALL clear the issued lane's pending bit and increment req_count.
REQ-027 When the handshake clears the last pending bit, the next state SHALL be DRAIN if fin_seen = 1, otherwise IDLE.
REQ-028 mem_req_valid SHALL be 0 in IDLE, DRAIN and DONE.
REQ-029 outstanding update: +1 on handshake only; -1 on mem_resp_valid only; unchanged when both occur in the same cycle.
REQ-030 mem_resp_valid with outstanding == 0 SHALL set resp_error and leave outstanding at 0.
REQ-031 DRAIN: when outstanding == 0, the next state SHALL be DONE; in_ready = 0.
REQ-032 DONE: finished = 1 and in_ready = 0; the block SHALL hold there until reset.
REQ-033 Timing: a vector accepted at cycle T SHALL have its first mem_req_valid at T+1; with ready held high, n set lanes SHALL issue on T+1..T+n, and in_ready SHALL be 1 again at T+n+1.
REQ-034 Payload outputs SHALL stay stable while mem_req_valid = 1 and mem_req_ready = 0.

Reset
REQ-035 While reset = 0, the block SHALL go to IDLE and clear pending, fin_seen, outstanding, req_count, finished and resp_error, with in_ready = 0 and mem_req_valid = 0.
REQ-036 Reset asserted mid-ISSUE or mid-DRAIN SHALL drop un-issued lanes and in-flight accounting; on the first cycle after release, in_ready SHALL be 1.

Verification
REQ-037 in_valid=4'b1011, mem_req_ready=1, response 2 cycles after each request -> lanes 0,1,3 issued on consecutive cycles, req_count=3, in_ready high 4 cycles after acceptance.
REQ-038 mem_req_ready=0 for 5 cycles during lane 1 -> mem_req_lane=1 and payload held constant; no duplicate issue.
REQ-039 MAX_OUTSTANDING=2, no responses, in_valid=4'b1111 -> exactly 2 issued, valid low; one response -> lane 2 issued on the next cycle.
REQ-040 Handshake and response in the same cycle with outstanding=1 -> outstanding stays 1.
REQ-041 Last vector with in_finished=1, responses delayed 10 cycles -> DRAIN until outstanding=0, then finished=1 sticky; response at outstanding=0 -> resp_error=1.
REQ-042 reset=0 during ISSUE with 2 lanes pending -> next cycle after release: in_ready=1, outstanding=0, req_count=0.
